bfm_adder: RTL and testbench
============================

# bfm_adder

Registered two-operand unsigned adder driven by the stimulus wrapper each clock: sums 8-bit operands `A_s` and `B_s` and presents the result on `res_o` after a fixed pipeline latency. It is the leaf datapath block under test in the cocotb example, sitting directly below the stimulus wrapper. It has no handshake; every clock edge accepts a new operand pair.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: operand and result width in bits.
- `PIPE_STAGES`, default 1: register stages from operands to `res_o`; legal range 1..4.

Ports:
- `clk_i`, input, 1 bit: clock; rising edge active.
- `reset_i`, input, 1 bit: asynchronous, active-low reset. Asserting it clears the pipeline immediately, without waiting for a clock edge.
- `A_s`, input, `DATA_WIDTH` bits: operand A, unsigned.
- `B_s`, input, `DATA_WIDTH` bits: operand B, unsigned.
- `res_o`, output, `DATA_WIDTH` bits: registered sum.

## Operation

- Each rising edge of `clk_i` with `reset_i` high samples `A_s` and `B_s`.
  - Stage 1 register captures the sum.
  - Stages 2..`PIPE_STAGES` shift that value forward unchanged.
- The sum is computed at `DATA_WIDTH+1` bits.
  - Default build: the carry is discarded, so the result wraps modulo 2^`DATA_WIDTH` (8'hFF + 8'h01 = 8'h00).
  - `BFM_SATURATE_EN` build: see Configuration.
- There is no valid/ready signalling. Every sampled pair produces exactly one result, in order.
- Inputs with X or Z values are not handled specially; they propagate to the output.

## Timing

- Latency is `PIPE_STAGES` clocks. With the default of 1, the result appears on `res_o` right after the edge that samples the operands.
- Throughput is one result per clock.
- Reset:
  - `reset_i` low forces every pipeline register, and therefore `res_o`, to 0 asynchronously.
  - While `reset_i` is held low, operands are ignored.
  - Deassertion must be synchronous to the clock; the integrator guarantees this.
  - The first edge with `reset_i` high samples live operands.
- Reset asserted mid-operation discards all in-flight results. None are replayed after reset is released.
- Pipeline fill: after reset release, `res_o` reads 0 until the first sampled result reaches the output, i.e. for `PIPE_STAGES` clocks.
- Operands that are constant across edges produce the same result every clock. No edge detection is done.

## Configuration

- Macro: `BFM_SATURATE_EN`.
- Defined: the stage-1 register captures all-ones (8'hFF at the default width) whenever the carry out is set, e.g. 8'hF0 + 8'h20 = 8'hFF.
- Undefined: wrap-around modulo 2^`DATA_WIDTH`.
- Latency and reset behaviour are identical in both builds.

## Structure

- Package `bfm_pkg` holds:
  - constant `BFM_DATA_WIDTH = 8`;
  - typedef `bfm_data_t` (logic [`BFM_DATA_WIDTH`-1:0]);
  - constant `BFM_SAT_MAX` (all ones).
- Sub-module `bfm_pipe_reg`: one resettable `DATA_WIDTH` register with async active-low clear.
  - The top level instantiates it `PIPE_STAGES` times with a generate loop.
  - The adder, carry logic and optional saturation sit ahead of stage 1.
- An elaboration-time check rejects `PIPE_STAGES` outside 1..4.

## Test plan

- **Reset:** hold `reset_i` low for 5 clocks with A=8'h12, B=8'h34.
  - `res_o` stays 8'h00 throughout.
  - One clock after release, `res_o` = 8'h46.
- **Stream:** drive A=k, B=2k for k=0..99, one pair per clock.
  - `res_o` = 3k mod 256, always `PIPE_STAGES` clocks behind the pair it belongs to.
  - No gaps in the output sequence.
- **Boundary:** A=8'hFF, B=8'h01.
  - Default build: 8'h00.
  - `BFM_SATURATE_EN` build: 8'hFF.
  - A=8'h80, B=8'h7F gives 8'hFF in both builds.
- **Mid-stream reset:** pull `reset_i` low between clock edges during the stream.
  - `res_o` goes to 0 immediately, without waiting for an edge.
  - After release, only post-reset operand sums appear.
- **Latency sweep:** `PIPE_STAGES` = 1, 2, 4 with a single nonzero pulse A=8'h05, B=8'h0A against zero operands elsewhere.
  - 8'h0F appears exactly `PIPE_STAGES` edges after it is sampled.
  - It is held for exactly one clock.

Source files
------------

// File: rtl/bfm_pkg.sv
// Shared width, data type and saturation constant for the bfm adder slice.
package bfm_pkg;

    localparam int BFM_DATA_WIDTH = 8;

    typedef logic [BFM_DATA_WIDTH-1:0] bfm_data_t;

    localparam bfm_data_t BFM_SAT_MAX = '1;

endpackage : bfm_pkg

// File: rtl/bfm_pipe_reg.sv
// One pipeline stage of the bfm adder: a DATA_WIDTH register that clears
// asynchronously while reset_i is low.
module bfm_pipe_reg
    import bfm_pkg::*;
#(
    parameter int DATA_WIDTH = BFM_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule : bfm_pipe_reg

// File: rtl/bfm_adder.sv
// Registered unsigned adder with PIPE_STAGES (1..4) of latency.
// Build option BFM_SATURATE_EN: clamp to all-ones on carry out instead of wrapping.
module bfm_adder
    import bfm_pkg::*;
#(
    parameter int DATA_WIDTH  = BFM_DATA_WIDTH,
    parameter int PIPE_STAGES = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] A_s,
    input  logic [DATA_WIDTH-1:0] B_s,
    output logic [DATA_WIDTH-1:0] res_o
);

    // No valid/ready: every clock edge with reset_i high accepts an operand
    // pair and the matching sum leaves res_o PIPE_STAGES edges later, in order.

    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
            $error("bfm_adder: PIPE_STAGES must be in 1..4");
        end
    endgenerate

    // stage[0] is the combinational sum feeding the first register.
    logic [DATA_WIDTH-1:0] stage [0:PIPE_STAGES];

`ifdef BFM_SATURATE_EN
    logic [DATA_WIDTH:0] sum_full;

    assign sum_full = {1'b0, A_s} + {1'b0, B_s};
    assign stage[0] = sum_full[DATA_WIDTH] ? {DATA_WIDTH{1'b1}}
                                           : sum_full[DATA_WIDTH-1:0];
`else
    // Carry falls off the top, giving wrap-around modulo 2^DATA_WIDTH.
    assign stage[0] = A_s + B_s;
`endif

    generate
        for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
            bfm_pipe_reg #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_reg (
                .clk_i  (clk_i),
                .reset_i(reset_i),
                .d      (stage[i]),
                .q      (stage[i+1])
            );
        end
    endgenerate

    assign res_o = stage[PIPE_STAGES];

endmodule : bfm_adder

// File: tb/tb_bfm_adder.sv
// Directed bench for bfm_adder: three instances (1, 2 and 4 stages) share
// the operand and reset stimulus; expected sums are hand-computed per vector.
module tb_bfm_adder;

    logic       clk_i;
    logic       reset_i;
    logic [7:0] A_s;
    logic [7:0] B_s;
    logic [7:0] res_p1;
    logic [7:0] res_p2;
    logic [7:0] res_p4;

    int n_checks;
    int n_pass;

    // Expected output history for each latency; index 0 is the newest sum.
    logic [7:0]       exp_p1;
    logic [1:0][7:0]  exp_p2;
    logic [3:0][7:0]  exp_p4;

    bfm_adder #(.DATA_WIDTH(8), .PIPE_STAGES(1)) dut_p1 (
        .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s), .res_o(res_p1));
    bfm_adder #(.DATA_WIDTH(8), .PIPE_STAGES(2)) dut_p2 (
        .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s), .res_o(res_p2));
    bfm_adder #(.DATA_WIDTH(8), .PIPE_STAGES(4)) dut_p4 (
        .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s), .res_o(res_p4));

    // Clock/reset block
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_p1 = '0;
        exp_p2 = '0;
        exp_p4 = '0;
    endtask

    // Drive one operand pair, let one edge pass, then compare all instances.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] sum);
        A_s = a;
        B_s = b;
        @(posedge clk_i);
        #1;
        if (reset_i) begin
            exp_p1 = sum;
            exp_p2 = {exp_p2[0], sum};
            exp_p4 = {exp_p4[2:0], sum};
        end else begin
            clear_model();
        end
        check("res_p1", res_p1, exp_p1);
        check("res_p2", res_p2, exp_p2[1]);
        check("res_p4", res_p4, exp_p4[3]);
    endtask

    logic [7:0] sat_ff_01;
    logic [7:0] sat_f0_20;
    int         hits;
    int         first_hit;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_model();
`ifdef BFM_SATURATE_EN
        sat_ff_01 = 8'hFF;
        sat_f0_20 = 8'hFF;
`else
        sat_ff_01 = 8'h00;
        sat_f0_20 = 8'h10;
`endif
        reset_i = 1'b0;
        A_s     = 8'h12;
        B_s     = 8'h34;
        #1;
        check("reset_p1_t0", res_p1, 8'h00);
        check("reset_p4_t0", res_p4, 8'h00);

        // Reset held for 5 clocks with live operands: outputs stay zero.
        for (int i = 0; i < 5; i++) step(8'h12, 8'h34, 8'h46);
        reset_i = 1'b1;
        step(8'h12, 8'h34, 8'h46);

        // Stream A=k, B=2k; expected 3k mod 256.
        for (int k = 0; k < 100; k++) begin
            step(8'(k), 8'(2 * k), 8'((3 * k) % 256));
            if (k == 60) begin
                // Mid-stream reset between edges: outputs drop without a clock.
                #2;
                reset_i = 1'b0;
                #1;
                check("midrst_p1", res_p1, 8'h00);
                check("midrst_p2", res_p2, 8'h00);
                check("midrst_p4", res_p4, 8'h00);
                clear_model();
                step(8'h55, 8'h22, 8'h77);
                reset_i = 1'b1;
            end
        end

        // Boundary vectors.
        step(8'hFF, 8'h01, sat_ff_01);
        step(8'h80, 8'h7F, 8'hFF);
        step(8'hF0, 8'h20, sat_f0_20);
        step(8'h00, 8'h00, 8'h00);
        step(8'hFF, 8'hFF, (sat_ff_01 == 8'hFF) ? 8'hFF : 8'hFE);

        // Latency sweep: one 8'h0F pulse among zeros.
        for (int i = 0; i < 5; i++) step(8'h00, 8'h00, 8'h00);
        hits      = 0;
        first_hit = -1;
        for (int e = 0; e < 8; e++) begin
            if (e == 0) step(8'h05, 8'h0A, 8'h0F);
            else        step(8'h00, 8'h00, 8'h00);
            if (res_p4 == 8'h0F) begin
                hits++;
                if (first_hit < 0) first_hit = e;
            end
        end
        check("pulse_p4_hits", 8'(hits), 8'd1);
        check("pulse_p4_edge", 8'(first_hit), 8'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bfm_adder
